// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter funnelling NumPorts cache requesters onto one memory adapter
// channel, with per-port outstanding limits and port-tagged return routing.
module wt_mem_req_arbiter #(
  parameter int NumPorts       = 2,
  parameter int PayloadWidth   = 128,
  parameter int TidWidth       = 2,
  parameter int RtrnWidth      = 256,
  parameter int MaxOutstanding = 4,
  localparam int PortW         = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumPorts-1:0]              req_i,
  input  logic [NumPorts*PayloadWidth-1:0] req_data_i,
  input  logic [NumPorts*TidWidth-1:0]     req_tid_i,
  output logic [NumPorts-1:0]              ack_o,
  output logic                             mem_req_o,
  input  logic                             mem_ack_i,
  output logic [PayloadWidth-1:0]          mem_data_o,
  output logic [PortW+TidWidth-1:0]        mem_tid_o,
  input  logic                             mem_rtrn_vld_i,
  input  logic [PortW+TidWidth-1:0]        mem_rtrn_tid_i,
  input  logic                             mem_rtrn_inv_i,
  input  logic [RtrnWidth-1:0]             mem_rtrn_data_i,
  output logic [NumPorts-1:0]              rtrn_vld_o,
  output logic [TidWidth-1:0]              rtrn_tid_o,
  output logic [RtrnWidth-1:0]             rtrn_data_o,
  output logic [NumPorts-1:0]              busy_o,
  output logic                             err_o
);

  localparam int CntW = 4;
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e                    r_state;
  logic [PortW-1:0]          r_grant;
  logic [PortW-1:0]          r_rr;
  logic                      r_mem_req;
  logic [PayloadWidth-1:0]   r_mem_data;
  logic [PortW+TidWidth-1:0] r_mem_tid;
  logic [CntW-1:0]           r_cnt [NumPorts];
  logic [NumPorts-1:0]       r_rtrn_vld;
  logic [TidWidth-1:0]       r_rtrn_tid;
  logic [RtrnWidth-1:0]      r_rtrn_data;
  logic [NumPorts-1:0]       r_busy;
  logic                      r_err;

  logic [NumPorts-1:0]       w_elig;
  logic                      w_found;
  logic [PortW-1:0]          w_gnt;
  logic                      w_ack_hit;
  logic [PortW-1:0]          w_rtrn_port;
  logic                      w_port_ok;
  logic                      w_rtrn_hit;
  logic [NumPorts-1:0]       w_rtrn_onehot;
  logic [CntW-1:0]           w_cnt_nxt [NumPorts];
  logic [NumPorts-1:0]       w_busy_nxt;
  logic                      w_zero_err;
  logic                      w_drop_err;
  logic                      w_err_set;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      w_elig[p] = req_i[p] && (r_cnt[p] < CntMax);
    end
  end

  // Round-robin search starting at the pointer, wrapping modulo NumPorts.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (!w_found && w_elig[(int'(r_rr) + i) % NumPorts]) begin
        w_found = 1'b1;
        w_gnt   = PortW'((int'(r_rr) + i) % NumPorts);
      end
    end
  end

  assign w_ack_hit = (r_state == S_HOLD) && mem_ack_i;

  always_comb begin
    ack_o = '0;
    if (w_ack_hit) begin
      ack_o[r_grant] = 1'b1;
    end
  end

  assign w_rtrn_port = mem_rtrn_tid_i[PortW+TidWidth-1 -: PortW];
  assign w_port_ok   = int'(w_rtrn_port) < NumPorts;
  assign w_rtrn_hit  = mem_rtrn_vld_i && !mem_rtrn_inv_i && w_port_ok;
  assign w_drop_err  = mem_rtrn_vld_i && !mem_rtrn_inv_i && !w_port_ok;

  // A return to an idle port is forwarded but never drives the counter below zero.
  always_comb begin
    w_zero_err = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      logic inc;
      logic dec;
      inc = w_ack_hit && (r_grant == PortW'(p));
      dec = w_rtrn_hit && (w_rtrn_port == PortW'(p)) && (r_cnt[p] != '0);
      w_rtrn_onehot[p] = w_rtrn_hit && (w_rtrn_port == PortW'(p));
      w_zero_err = w_zero_err || (w_rtrn_hit && (w_rtrn_port == PortW'(p)) && (r_cnt[p] == '0));
      w_cnt_nxt[p]  = r_cnt[p] + CntW'(inc) - CntW'(dec);
      w_busy_nxt[p] = (w_cnt_nxt[p] != '0);
    end
  end

  assign w_err_set = ((r_state == S_HOLD) && !req_i[r_grant]) || w_zero_err || w_drop_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_data  <= '0;
      r_mem_tid   <= '0;
      r_rtrn_vld  <= '0;
      r_rtrn_tid  <= '0;
      r_rtrn_data <= '0;
      r_busy      <= '0;
      r_err       <= 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
        r_cnt[p] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_HOLD;
            r_grant    <= w_gnt;
            r_mem_req  <= 1'b1;
            r_mem_data <= req_data_i[int'(w_gnt)*PayloadWidth +: PayloadWidth];
            r_mem_tid  <= {w_gnt, req_tid_i[int'(w_gnt)*TidWidth +: TidWidth]};
          end
        end
        S_HOLD: begin
          if (mem_ack_i) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_rr      <= (r_grant == PortW'(NumPorts - 1)) ? '0 : r_grant + PortW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      for (int p = 0; p < NumPorts; p++) begin
        r_cnt[p] <= w_cnt_nxt[p];
      end
      r_busy <= w_busy_nxt;

      // Invalidations fan out to every port; ordinary returns go to the tagged port only.
      if (mem_rtrn_vld_i) begin
        r_rtrn_vld  <= mem_rtrn_inv_i ? '1 : w_rtrn_onehot;
        r_rtrn_tid  <= mem_rtrn_tid_i[TidWidth-1:0];
        r_rtrn_data <= mem_rtrn_data_i;
      end else begin
        r_rtrn_vld  <= '0;
      end

      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_data_o  = r_mem_data;
  assign mem_tid_o   = r_mem_tid;
  assign rtrn_vld_o  = r_rtrn_vld;
  assign rtrn_tid_o  = r_rtrn_tid;
  assign rtrn_data_o = r_rtrn_data;
  assign busy_o      = r_busy;
  assign err_o       = r_err;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Directed bench for wt_mem_req_arbiter with three ports so that an
// out-of-range port index in a return tid can be exercised.
module tb_wt_mem_req_arbiter;

  localparam int NP  = 3;
  localparam int PW  = 16;
  localparam int TW  = 2;
  localparam int RW  = 16;
  localparam int MO  = 4;
  localparam int PTW = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [NP-1:0]        req_i = '0;
  logic [NP*PW-1:0]     req_data_i = {16'hC002, 16'hB001, 16'hA000};
  logic [NP*TW-1:0]     req_tid_i  = {2'd3, 2'd2, 2'd1};
  logic [NP-1:0]        ack_o;
  logic                 mem_req_o;
  logic                 mem_ack_i = 1'b0;
  logic [PW-1:0]        mem_data_o;
  logic [PTW+TW-1:0]    mem_tid_o;
  logic                 mem_rtrn_vld_i = 1'b0;
  logic [PTW+TW-1:0]    mem_rtrn_tid_i = '0;
  logic                 mem_rtrn_inv_i = 1'b0;
  logic [RW-1:0]        mem_rtrn_data_i = '0;
  logic [NP-1:0]        rtrn_vld_o;
  logic [TW-1:0]        rtrn_tid_o;
  logic [RW-1:0]        rtrn_data_o;
  logic [NP-1:0]        busy_o;
  logic                 err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  wt_mem_req_arbiter #(
    .NumPorts(NP), .PayloadWidth(PW), .TidWidth(TW), .RtrnWidth(RW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .req_data_i(req_data_i),
    .req_tid_i(req_tid_i), .ack_o(ack_o), .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_tid_o(mem_tid_o), .mem_rtrn_vld_i(mem_rtrn_vld_i),
    .mem_rtrn_tid_i(mem_rtrn_tid_i), .mem_rtrn_inv_i(mem_rtrn_inv_i),
    .mem_rtrn_data_i(mem_rtrn_data_i), .rtrn_vld_o(rtrn_vld_o), .rtrn_tid_o(rtrn_tid_o),
    .rtrn_data_o(rtrn_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '0;
    mem_ack_i = 1'b0;
    mem_rtrn_vld_i = 1'b0;
    mem_rtrn_inv_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NP-1:0]     exp_ack;
    logic [PTW+TW-1:0] exp_tid;

    // Reset state
    step();
    step();
    check("rst_mem_req", 64'(mem_req_o), 64'h0);
    check("rst_ack", 64'(ack_o), 64'h0);
    check("rst_rtrn_vld", 64'(rtrn_vld_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_mem_tid", 64'(mem_tid_o), 64'h0);
    rst_ni = 1'b1;

    // Single request from port0, ack arrives in cycle 3
    req_i = 3'b001;
    step();
    check("single_mem_req_c1", 64'(mem_req_o), 64'h1);
    check("single_mem_tid", 64'(mem_tid_o), 64'h1);
    check("single_mem_data", 64'(mem_data_o), 64'hA000);
    check("single_no_ack_c1", 64'(ack_o), 64'h0);
    step();
    check("single_hold_c2", 64'(mem_req_o), 64'h1);
    step();
    mem_ack_i = 1'b1;
    #1;
    check("single_ack_c3", 64'(ack_o), 64'h1);
    step();
    req_i = '0;
    mem_ack_i = 1'b0;
    check("single_mem_req_drop", 64'(mem_req_o), 64'h0);
    check("single_busy", 64'(busy_o), 64'h1);

    // Return to port0 clears its count
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_tid_i = 4'h1;
    mem_rtrn_data_i = 16'h1234;
    step();
    mem_rtrn_vld_i = 1'b0;
    check("ret0_vld", 64'(rtrn_vld_o), 64'h1);
    check("ret0_tid", 64'(rtrn_tid_o), 64'h1);
    check("ret0_data", 64'(rtrn_data_o), 64'h1234);
    check("ret0_busy", 64'(busy_o), 64'h0);
    check("ret0_err", 64'(err_o), 64'h0);
    step();
    check("ret0_vld_pulse", 64'(rtrn_vld_o), 64'h0);

    // Fairness: pointer sits at 1 after the port0 grant, so order is 1,0,1,0
    req_i = 3'b011;
    mem_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_ack = (k % 2 == 0) ? 3'b010 : 3'b001;
      exp_tid = (k % 2 == 0) ? 4'h6 : 4'h1;
      step();
      check("fair_ack", 64'(ack_o), 64'(exp_ack));
      check("fair_tid", 64'(mem_tid_o), 64'(exp_tid));
      step();
      check("fair_gap", 64'(ack_o), 64'h0);
    end
    req_i = '0;
    mem_ack_i = 1'b0;
    check("fair_busy", 64'(busy_o), 64'h3);
    do_reset();
    check("reset_clears_busy", 64'(busy_o), 64'h0);

    // Outstanding limit on port0
    req_i = 3'b001;
    mem_ack_i = 1'b1;
    for (int k = 0; k < MO; k++) begin
      step();
      check("lim_ack", 64'(ack_o), 64'h1);
      step();
      check("lim_gap", 64'(ack_o), 64'h0);
    end
    step();
    check("lim_blocked_req", 64'(mem_req_o), 64'h0);
    check("lim_blocked_ack", 64'(ack_o), 64'h0);
    check("lim_busy", 64'(busy_o), 64'h1);
    req_i = 3'b011;
    step();
    check("lim_port1_ack", 64'(ack_o), 64'h2);
    check("lim_port1_tid", 64'(mem_tid_o), 64'h6);
    step();
    req_i = 3'b001;
    check("lim_port1_done", 64'(ack_o), 64'h0);
    step();
    check("lim_still_blocked", 64'(mem_req_o), 64'h0);
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_tid_i = 4'h1;
    step();
    mem_rtrn_vld_i = 1'b0;
    check("lim_ret_vld", 64'(rtrn_vld_o), 64'h1);
    check("lim_ret_no_grant_yet", 64'(mem_req_o), 64'h0);
    step();
    check("lim_regrant_req", 64'(mem_req_o), 64'h1);
    check("lim_regrant_ack", 64'(ack_o), 64'h1);
    check("lim_regrant_tid", 64'(mem_tid_o), 64'h1);
    step();
    req_i = '0;
    mem_ack_i = 1'b0;
    check("lim_busy_end", 64'(busy_o), 64'h3);
    do_reset();

    // Return routing and invalidation broadcast
    req_i = 3'b100;
    mem_ack_i = 1'b1;
    step();
    check("route_tid", 64'(mem_tid_o), 64'hB);
    check("route_ack", 64'(ack_o), 64'h4);
    step();
    req_i = '0;
    mem_ack_i = 1'b0;
    check("route_busy", 64'(busy_o), 64'h4);
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_inv_i = 1'b1;
    mem_rtrn_tid_i = 4'h0;
    mem_rtrn_data_i = 16'h5555;
    step();
    mem_rtrn_vld_i = 1'b0;
    mem_rtrn_inv_i = 1'b0;
    check("inv_vld", 64'(rtrn_vld_o), 64'h7);
    check("inv_data", 64'(rtrn_data_o), 64'h5555);
    check("inv_busy_kept", 64'(busy_o), 64'h4);
    check("inv_err", 64'(err_o), 64'h0);
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_tid_i = 4'hB;
    mem_rtrn_data_i = 16'hBEEF;
    step();
    mem_rtrn_vld_i = 1'b0;
    check("route_vld", 64'(rtrn_vld_o), 64'h4);
    check("route_rtid", 64'(rtrn_tid_o), 64'h3);
    check("route_data", 64'(rtrn_data_o), 64'hBEEF);
    check("route_busy_clr", 64'(busy_o), 64'h0);
    check("route_err", 64'(err_o), 64'h0);

    // Simultaneous ack and return on port1 with one transaction in flight
    req_i = 3'b010;
    mem_ack_i = 1'b1;
    step();
    step();
    step();
    check("sim_ack", 64'(ack_o), 64'h2);
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_tid_i = 4'h4;
    step();
    req_i = '0;
    mem_ack_i = 1'b0;
    mem_rtrn_vld_i = 1'b0;
    check("sim_rtrn_vld", 64'(rtrn_vld_o), 64'h2);
    check("sim_busy", 64'(busy_o), 64'h2);
    check("sim_err", 64'(err_o), 64'h0);
    mem_rtrn_vld_i = 1'b1;
    step();
    mem_rtrn_vld_i = 1'b0;
    check("sim_last_ret_busy", 64'(busy_o), 64'h0);
    check("sim_last_ret_err", 64'(err_o), 64'h0);
    mem_rtrn_vld_i = 1'b1;
    step();
    mem_rtrn_vld_i = 1'b0;
    check("zero_ret_fwd", 64'(rtrn_vld_o), 64'h2);
    check("zero_ret_err", 64'(err_o), 64'h1);
    check("zero_ret_busy", 64'(busy_o), 64'h0);
    step();
    check("err_sticky", 64'(err_o), 64'h1);
    do_reset();
    check("err_reset", 64'(err_o), 64'h0);

    // Port index 3 does not exist with three ports
    mem_rtrn_vld_i = 1'b1;
    mem_rtrn_tid_i = 4'hC;
    mem_rtrn_data_i = 16'h7777;
    step();
    mem_rtrn_vld_i = 1'b0;
    check("bad_port_dropped", 64'(rtrn_vld_o), 64'h0);
    check("bad_port_err", 64'(err_o), 64'h1);
    do_reset();

    // Requester drops req while held: error, transfer still completes
    req_i = 3'b001;
    step();
    check("drop_req_up", 64'(mem_req_o), 64'h1);
    req_i = '0;
    step();
    check("drop_err", 64'(err_o), 64'h1);
    check("drop_still_req", 64'(mem_req_o), 64'h1);
    mem_ack_i = 1'b1;
    #1;
    check("drop_ack", 64'(ack_o), 64'h1);
    step();
    mem_ack_i = 1'b0;
    check("drop_done", 64'(mem_req_o), 64'h0);
    do_reset();

    // Asynchronous reset while holding a request
    req_i = 3'b001;
    step();
    check("arst_req_up", 64'(mem_req_o), 64'h1);
    rst_ni = 1'b0;
    #1;
    check("arst_immediate", 64'(mem_req_o), 64'h0);
    req_i = '0;
    mem_ack_i = 1'b1;
    step();
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("arst_no_ack", 64'(ack_o), 64'h0);
      check("arst_no_req", 64'(mem_req_o), 64'h0);
    end
    mem_ack_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
